// File: rtl/spi_lcd_pkg.sv
// spi_lcd_pkg: shared definitions for the SPI LCD byte transmitter and the
// command/pixel sequencer that feeds it.
//   state_t      transmitter FSM states
//   OP_*         panel opcode bytes, so the sequencer and benches agree
//   cnt_width()  width of a counter that must hold 0..n-1 (at least 1 bit)
package spi_lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] OP_MADCTL  = 8'h36;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_RASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;
    localparam logic [7:0] OP_DISPON  = 8'h29;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_phase_tick.sv
// spi_phase_tick: divides clk into SCK half-periods of CLK_DIV cycles.
//   clk    system clock
//   rst    synchronous active-high reset
//   clear  restart the half-period count (byte transfer edge)
//   tick   high in the last cycle of each half-period
module spi_phase_tick
    import spi_lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    W    = cnt_width(CLK_DIV);
    localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_lcd_byte_tx.sv
// spi_lcd_byte_tx: byte-level SPI mode-0 transmitter for an LCD panel.
// Takes one byte plus D/C and last flags per valid/ready handshake, shifts it
// MSB-first, and keeps chip-select low across bytes until a 'last' byte ends.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_data/i_dc/i_last  byte, D/C flag, release-CS flag (sampled on transfer)
//   i_valid, o_ready    handshake; transfer when both high at a rising edge
//   o_done              one-cycle pulse after a byte's final SCK high phase
//   o_busy              state is not IDLE
//   o_mosi/o_clk/o_cs/o_dc  panel pins (SCK idle low, CS active-low)
module spi_lcd_byte_tx
    import spi_lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    input  logic       i_last,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_mosi,
    output logic       o_clk,
    output logic       o_cs,
    output logic       o_dc
);

    localparam int unsigned      GAP_W    = cnt_width(CS_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    state_t           state;
    logic [6:0]       shreg;      // bits still to send after the one on o_mosi
    logic [2:0]       bit_idx;
    logic             last_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             tick;
    logic             xfer;

    assign xfer   = i_valid && o_ready;
    assign o_busy = (state != IDLE);

    spi_phase_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (xfer),
        .tick  (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_cs    <= 1'b1;
            o_clk   <= 1'b0;
            o_mosi  <= 1'b0;
            o_dc    <= 1'b0;
            o_done  <= 1'b0;
            o_ready <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            last_q  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (xfer) begin
                        state   <= SHIFT_LO;
                        o_mosi  <= i_data[7];
                        shreg   <= i_data[6:0];
                        bit_idx <= 3'd7;
                        o_dc    <= i_dc;
                        last_q  <= i_last;
                        o_cs    <= 1'b0;
                        o_clk   <= 1'b0;
                        o_ready <= 1'b0;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        state <= SHIFT_HI;
                        o_clk <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        o_clk <= 1'b0;
                        if (bit_idx == 3'd0) begin
                            o_done <= 1'b1;
                            if (last_q) begin
                                o_cs   <= 1'b1;
                                o_mosi <= 1'b0;
                                if (CS_GAP == 0) begin
                                    state   <= IDLE;
                                    o_ready <= 1'b1;
                                end else begin
                                    state   <= GAP;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                // mosi keeps bit 0 while CS stays framed
                                state   <= HOLD;
                                o_ready <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                            o_mosi  <= shreg[6];
                            shreg   <= {shreg[5:0], 1'b0};
                            state   <= SHIFT_LO;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        o_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_lcd_byte_tx.sv
// tb_spi_lcd_byte_tx: self-checking bench for spi_lcd_byte_tx.
// Main instance uses CLK_DIV=2/CS_GAP=2; a second CLK_DIV=1/CS_GAP=0 instance
// covers maximum rate. Bytes pushed by send() are popped by an SPI sampler.
module tb_spi_lcd_byte_tx;
    import spi_lcd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, dc, last;
    logic [7:0] data;
    logic       ready, done, busy, mosi, sck, cs, dco;

    logic       v1, dcin1, l1;
    logic [7:0] d1;
    logic       r1, dn1, b1, m1, s1, c1, dco1;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
    } exp_t;
    exp_t sbq[$];

    spi_lcd_byte_tx #(.CLK_DIV(2), .CS_GAP(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_dc(dc), .i_last(last),
        .i_valid(valid), .o_ready(ready), .o_done(done), .o_busy(busy),
        .o_mosi(mosi), .o_clk(sck), .o_cs(cs), .o_dc(dco)
    );

    spi_lcd_byte_tx #(.CLK_DIV(1), .CS_GAP(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(d1), .i_dc(dcin1), .i_last(l1),
        .i_valid(v1), .o_ready(r1), .o_done(dn1), .o_busy(b1),
        .o_mosi(m1), .o_clk(s1), .o_cs(c1), .o_dc(dco1)
    );

    // SPI sampler for the main instance: rebuilds bytes on SCK rising edges
    initial begin : sampler
        logic       pclk;
        int         nb;
        logic [7:0] sh;
        logic       pend_last;
        bit         have;
        exp_t       e;
        pclk = 1'b0; nb = 0; sh = '0; pend_last = 1'b0; have = 1'b0;
        forever begin
            @(negedge clk);
            if (sck === 1'b1 && pclk === 1'b0 && cs === 1'b0) begin
                sh = {sh[6:0], mosi};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_byte got=%02h required none", sh);
                    end else begin
                        e = sbq.pop_front();
                        if (sh !== e.data || dco !== e.dc) begin
                            errors++;
                            $display("FAIL sb_byte got=%02h dc=%b required %02h dc=%b",
                                     sh, dco, e.data, e.dc);
                        end
                        pend_last = e.last;
                        have      = 1'b1;
                    end
                end
            end
            if (cs === 1'b1) nb = 0;
            if (done === 1'b1) begin
                checks++;
                if (!have || cs !== pend_last) begin
                    errors++;
                    $display("FAIL sb_cs_framing cs=%b at done required %b (byte seen %0b)",
                             cs, pend_last, have);
                end
                have = 1'b0;
            end
            pclk = sck;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog sim time expired required finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] d, input logic dci, input logic lst,
                        input bit track, output int unsigned t);
        int unsigned budget;
        exp_t e;
        budget = 0;
        data = d; dc = dci; last = lst; valid = 1'b1;
        if (track) begin
            e.data = d; e.dc = dci; e.last = lst;
            sbq.push_back(e);
        end
        while (ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout ready=%b required 1", ready);
            valid = 1'b0;
            t = 0;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc - 1;
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_idle busy=%b ready=%b required 0/1", busy, ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data = '0; dc = 1'b0; last = 1'b0;
        v1 = 1'b0; d1 = '0; dcin1 = 1'b0; l1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cs, sck, mosi, dco, done, busy, ready} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_state cs,clk,mosi,dc,done,busy,ready=%b required 1000000",
                     {cs, sck, mosi, dco, done, busy, ready});
        end
        checks++;
        if ({c1, s1, m1, dn1, b1, r1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_state_div1 got=%b required 100000", {c1, s1, m1, dn1, b1, r1});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready ready=%b required 1", ready);
        end
    endtask

    task automatic test_single_cmd();
        int unsigned t;
        int          rises, bad_cs, bad_done;
        logic [7:0]  bits;
        logic        pclk;
        logic        rdy34, rdy35;
        rises = 0; bad_cs = 0; bad_done = 0; bits = '0; pclk = 1'b0;
        rdy34 = 1'b1; rdy35 = 1'b0;
        send(8'hA5, 1'b0, 1'b1, 1'b1, t);
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (sck === 1'b1 && pclk === 1'b0) begin
                rises++;
                bits = {bits[6:0], mosi};
            end
            pclk = sck;
            if (cs !== (i >= 33)) bad_cs++;
            if (done !== (i == 33)) bad_done++;
            if (i == 34) rdy34 = ready;
            if (i == 35) rdy35 = ready;
        end
        checks++;
        if (rises != 8) begin errors++; $display("FAIL single_rises got=%0d required 8", rises); end
        checks++;
        if (bits !== 8'hA5) begin errors++; $display("FAIL single_bits got=%02h required a5", bits); end
        checks++;
        if (bad_cs != 0) begin errors++; $display("FAIL single_cs_window bad_cycles=%0d required 0", bad_cs); end
        checks++;
        if (bad_done != 0) begin errors++; $display("FAIL single_done_cycle bad_cycles=%0d required 0", bad_done); end
        checks++;
        if (rdy34 !== 1'b0) begin errors++; $display("FAIL single_ready_gap ready=%b required 0", rdy34); end
        checks++;
        if (rdy35 !== 1'b1) begin errors++; $display("FAIL single_ready_back ready=%b required 1", rdy35); end
    endtask

    task automatic test_cmd_data();
        logic [39:0] seq;
        int unsigned t;
        int          nd, rises;
        logic        pcs;
        seq = {OP_CASET, 8'h00, 8'h0A, 8'h00, 8'h0F};
        nd = 0; rises = 0; pcs = cs;
        fork
            begin
                for (int b = 0; b < 5; b++)
                    send(seq[39-8*b -: 8], b != 0, b == 4, 1'b1, t);
            end
            begin
                repeat (230) begin
                    @(negedge clk);
                    if (pcs === 1'b0 && cs === 1'b1) rises++;
                    pcs = cs;
                    if (done === 1'b1) begin
                        if (nd < 5) begin
                            checks++;
                            if (dco !== (nd != 0)) begin
                                errors++;
                                $display("FAIL txn_dc byte=%0d dc=%b required %b", nd, dco, nd != 0);
                            end
                        end
                        nd++;
                    end
                end
            end
        join
        checks++;
        if (nd != 5) begin errors++; $display("FAIL txn_done_count got=%0d required 5", nd); end
        checks++;
        if (rises != 1) begin errors++; $display("FAIL txn_cs_rises got=%0d required 1", rises); end
    endtask

    task automatic test_busy_reject();
        int unsigned t, t2;
        int          n;
        send(8'h3C, 1'b1, 1'b1, 1'b1, t);
        data = 8'hFF; dc = 1'b0; last = 1'b1; valid = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 35) begin errors++; $display("FAIL busy_ready_return cycle=%0d required 35", n); end
        send(8'hFF, 1'b0, 1'b1, 1'b1, t2);
        checks++;
        if (t2 - t != 35) begin
            errors++;
            $display("FAIL busy_next_xfer spacing=%0d required 35", t2 - t);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned t;
        int          rises, n;
        logic        pclk;
        bit          saw_done;
        rises = 0; n = 0; pclk = 1'b0; saw_done = 1'b0;
        send(8'hC3, 1'b1, 1'b1, 1'b0, t);
        while (rises < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (sck === 1'b1 && pclk === 1'b0) rises++;
            pclk = sck;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (rises != 3) begin errors++; $display("FAIL rstmid_edges got=%0d required 3", rises); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs, sck, mosi, busy, done} !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_state cs,clk,mosi,busy,done=%b required 10000",
                     {cs, sck, mosi, busy, done});
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL rstmid_no_done saw_done=1 required 0"); end
        send(8'h96, 1'b0, 1'b1, 1'b1, t);
    endtask

    task automatic test_max_rate();
        logic [31:0] exp32, got;
        int unsigned ts[4];
        int          rises, hi_run, bad_hi, bad_rdy, n;
        logic        pclk;
        exp32 = {OP_RAMWR, 8'h81, 8'h7E, OP_DISPON};
        got = '0; rises = 0; hi_run = 0; bad_hi = 0; bad_rdy = 0; pclk = 1'b0;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    d1 = exp32[31-8*b -: 8]; dcin1 = b[0]; l1 = (b == 3); v1 = 1'b1;
                    n = 0;
                    while (r1 !== 1'b1 && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    @(posedge clk);
                    #1;
                    ts[b] = cyc - 1;
                end
                v1 = 1'b0;
            end
            begin
                repeat (90) begin
                    @(negedge clk);
                    if (s1 === 1'b1 && pclk === 1'b0) begin
                        rises++;
                        got = {got[30:0], m1};
                    end
                    if (s1 === 1'b1) hi_run++;
                    else if (hi_run > 0) begin
                        if (hi_run != 1) bad_hi++;
                        hi_run = 0;
                    end
                    if (dn1 === 1'b1 && r1 !== 1'b1) bad_rdy++;
                    pclk = s1;
                end
            end
        join
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (ts[b+1] - ts[b] != 17) begin
                errors++;
                $display("FAIL maxrate_spacing byte=%0d spacing=%0d required 17", b, ts[b+1] - ts[b]);
            end
        end
        checks++;
        if (rises != 32) begin errors++; $display("FAIL maxrate_rises got=%0d required 32", rises); end
        checks++;
        if (got !== exp32) begin errors++; $display("FAIL maxrate_bits got=%08h required %08h", got, exp32); end
        checks++;
        if (bad_hi != 0) begin errors++; $display("FAIL maxrate_high_phase bad=%0d required 0", bad_hi); end
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL maxrate_ready_at_done bad=%0d required 0", bad_rdy); end
        checks++;
        if (c1 !== 1'b1) begin errors++; $display("FAIL maxrate_cs_end cs=%b required 1", c1); end
    endtask

    task automatic test_random();
        int unsigned t;
        logic [31:0] r;
        int          n;
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            send(r[15:8], r[0], (i == 199) || (r[17:16] == 2'b00), 1'b1, t);
            repeat (r[21:20] % 3) @(negedge clk);
        end
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL random_drain left=%0d required 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        wait_idle();
        test_cmd_data();
        wait_idle();
        test_busy_reject();
        wait_idle();
        test_reset_mid();
        wait_idle();
        test_max_rate();
        test_random();
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_lcd_byte_tx.md
Name: spi_lcd_byte_tx

Overview:
Byte-level SPI transmitter that sits directly downstream of the LCD command/pixel sequencer inside the SPI display top.
- Accepts one byte plus a D/C flag per valid/ready handshake.
- Serialises each byte MSB-first in SPI mode 0 onto the panel pins.
- Frames chip-select across multi-byte transactions.
- Owns no panel knowledge. The sequencer decides byte content, D/C and transaction boundaries.

Parameters:
- CLK_DIV, 2, i_clk cycles per SCK half-period (>=1). SCK frequency is f(i_clk)/(2*CLK_DIV).
- CS_GAP, 2, i_clk cycles o_cs stays high after a transaction ends, before o_ready returns (>=0).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_data  in  8  byte to send
- i_dc  in  1  0 = command, 1 = data; latched with the byte
- i_last  in  1  1 = release CS after this byte; latched with the byte
- i_valid  in  1  byte offered
- o_ready  out  1  transmitter can accept a byte this cycle
- o_done  out  1  one-cycle pulse when a byte's last SCK edge completes
- o_busy  out  1  high whenever state is not IDLE
- o_mosi  out  1  serial data to panel
- o_clk  out  1  SCK, idle low
- o_cs  out  1  chip select, active-low
- o_dc  out  1  D/C to panel

Behaviour:
- Reset (i_rst=1 at a rising edge), next-cycle values: o_cs=1, o_clk=0, o_mosi=0, o_dc=0, o_done=0, o_busy=0, o_ready=0.
  - o_ready is 1 from the first cycle after i_rst deasserts.
  - Reset mid-byte aborts immediately. No partial-byte completion and no o_done.
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP.
- Handshake:
  - Transfer occurs when i_valid && o_ready at a rising edge (cycle T).
  - o_ready=1 only in IDLE and HOLD.
  - i_valid in other states is ignored, with no buffering.
  - i_data, i_dc and i_last are sampled only at the transfer edge.
- Per byte, with transfer at T, k = CLK_DIV, bit b from 7 down to 0, n = 7-b:
  - SHIFT_LO for bit b covers cycles T+1+2nk .. T+(2n+1)k. o_clk=0, o_mosi=bit b.
  - SHIFT_HI for bit b covers cycles T+(2n+1)k+1 .. T+(2n+2)k. o_clk=1, o_mosi holds bit b. The panel samples on the rising edge.
  - o_cs=0 and o_dc=latched dc from T+1 for the whole byte.
- Cycle T+16k+1: o_clk=0 and o_done=1 for this one cycle.
  - If last=0: enter HOLD. o_cs stays 0, o_mosi holds bit0, o_ready=1. A transfer in HOLD starts the next byte with the same timing and no CS toggle. o_dc may change at T'+1, while SCK is low.
  - If last=1: o_cs=1, o_mosi=0, then GAP for CS_GAP cycles, then IDLE (o_ready=1). With CS_GAP=0, IDLE is entered directly at T+16k+1.
- HOLD has no timeout. The sequencer must eventually send a byte with last=1.
- Throughput within a transaction: one byte per 16k+1 cycles minimum.
- SCK never glitches. Every high phase is exactly k cycles and every low phase is at least k cycles.
- Bit counter is 3 bits and phase counter is clog2(CLK_DIV) bits. No wrap beyond bit0.

Decomposition:
- Package spi_lcd_pkg:
  - state encoding.
  - panel opcode constants shared with the sequencer: SWRESET 0x01, SLPOUT 0x11, COLMOD 0x3A, MADCTL 0x36, CASET 0x2A, RASET 0x2B, RAMWR 0x2C, DISPON 0x29.
- Sub-module spi_phase_tick: a CLK_DIV counter emitting a one-cycle tick at each half-period end. It is cleared on a transfer edge and on i_rst.

Test Plan:
- Single command: CLK_DIV=2, CS_GAP=2, send 0xA5 with dc=0, last=1 at T → o_cs low for T+1..T+32; exactly 8 SCK rising edges; mosi sampled at the rising edges = 1,0,1,0,0,1,0,1; o_done at T+33; o_cs high at T+33; o_ready=1 at T+35.
- Command plus data transaction: 0x2A (dc=0), 0x00, 0x0A, 0x00, 0x0F (dc=1, last on the final byte) → o_cs stays low through all 5 bytes; o_dc=0 during byte 1 and 1 during bytes 2-5; 5 o_done pulses; o_cs rises exactly once.
- Busy rejection: hold i_valid=1 with 0xFF during a 0x3C byte → 0x3C shifted unchanged; o_ready=0 until HOLD or IDLE; the next accepted byte is 0xFF.
- Reset mid-byte: assert i_rst after the 3rd SCK rising edge → next cycle o_cs=1, o_clk=0, o_mosi=0, o_busy=0; no o_done; the next byte after reset transmits cleanly.
- Max rate: CLK_DIV=1, continuous valid, 4 bytes with last on the 4th → byte spacing 17 cycles; SCK high phases are 1 cycle; 32 rising edges total.
- Scoreboard: random bytes, dc and last over 200 transfers, with a bench-side SPI sampler on o_clk rising edges while o_cs=0 → every byte and its dc match; CS framing matches the last flags.
